// File: rtl/uc_multiciclo.sv
// uc_multiciclo: multicycle RV64 control unit sequencing fetch/decode/exec/mem/writeback
// with ready handshakes, illegal-opcode and memory-timeout traps.
module uc_multiciclo #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int COUNT_BITS     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic [3:0]            alu_flags,
    input  logic                  i_mem_ready,
    input  logic                  d_mem_ready,
    output logic                  i_mem_req,
    output logic                  d_mem_req,
    output logic                  d_mem_we,
    output logic                  rf_we,
    output logic [3:0]            alu_cmd,
    output logic                  alu_src,
    output logic                  pc_src,
    output logic                  rf_src,
    output logic                  pc_we,
    output logic                  halted,
    output logic                  illegal,
    output logic                  bus_error,
    output logic [COUNT_BITS-1:0] instr_count
);
    localparam int WAIT_BITS = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_BITS-1:0] WAIT_MAX = WAIT_BITS'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
    typedef enum logic [2:0] {C_R, C_OPI, C_LOAD, C_JALR, C_STORE, C_BRANCH, C_U, C_JAL} class_t;

    state_t                r_state;
    class_t                r_class;
    logic [WAIT_BITS-1:0]  r_wait;
    logic [COUNT_BITS-1:0] r_count;
    logic [3:0]            r_alu_cmd;
    logic r_i_mem_req, r_d_mem_req, r_d_mem_we, r_rf_we, r_alu_src, r_pc_src, r_rf_src;
    logic r_pc_we, r_halted, r_illegal, r_bus_error;

    class_t     w_class;
    logic       w_valid, w_taken, w_mem, w_go_wb;
    logic [3:0] w_cmd;

    always_comb begin
        w_class = C_R;
        w_valid = 1'b1;
        case (opcode)
            7'b0110011: w_class = C_R;
            7'b0010011: w_class = C_OPI;
            7'b0000011: w_class = C_LOAD;
            7'b1100111: w_class = C_JALR;
            7'b0100011: w_class = C_STORE;
            7'b1100011: begin
                w_class = C_BRANCH;
                w_valid = funct3[2:1] != 2'b01;
            end
            7'b0110111, 7'b0010111: w_class = C_U;
            7'b1101111: w_class = C_JAL;
            default: w_valid = 1'b0;
        endcase
    end

    assign w_cmd = (w_class == C_R)      ? 4'd0 :
                   (w_class == C_STORE)  ? 4'd2 :
                   (w_class == C_BRANCH) ? 4'd3 :
                   (w_class == C_U)      ? 4'd4 :
                   (w_class == C_JAL)    ? 4'd5 : 4'd1;

    // funct3[0] inverts the base condition: BEQ/BNE, BLT/BGE, BLTU/BGEU
    assign w_taken = (funct3[2] ? (funct3[1] ? alu_flags[3] : alu_flags[1] ^ alu_flags[2])
                                : alu_flags[0]) ^ funct3[0];
    assign w_mem   = (r_class == C_LOAD) || (r_class == C_STORE);
    assign w_go_wb = ((r_state == S_EXEC) && !w_mem) || ((r_state == S_MEM) && d_mem_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_FETCH;
            r_class     <= C_R;
            r_wait      <= '0;
            r_count     <= '0;
            r_alu_cmd   <= '0;
            r_i_mem_req <= 1'b0;
            r_d_mem_req <= 1'b0;
            r_d_mem_we  <= 1'b0;
            r_rf_we     <= 1'b0;
            r_alu_src   <= 1'b0;
            r_pc_src    <= 1'b0;
            r_rf_src    <= 1'b0;
            r_pc_we     <= 1'b0;
            r_halted    <= 1'b0;
            r_illegal   <= 1'b0;
            r_bus_error <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (!r_i_mem_req) begin
                        r_i_mem_req <= 1'b1;
                    end else if (i_mem_ready) begin
                        r_i_mem_req <= 1'b0;
                        r_state     <= S_DECODE;
                    end else if (r_wait == WAIT_MAX) begin
                        r_i_mem_req <= 1'b0;
                        r_halted    <= 1'b1;
                        r_bus_error <= 1'b1;
                        r_state     <= S_TRAP;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_DECODE: begin
                    if (!w_valid) begin
                        r_halted  <= 1'b1;
                        r_illegal <= 1'b1;
                        r_state   <= S_TRAP;
                    end else begin
                        r_class   <= w_class;
                        r_alu_cmd <= w_cmd;
                        r_alu_src <= !((w_class == C_R) || (w_class == C_BRANCH));
                        r_rf_src  <= w_class == C_LOAD;
                        r_state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_mem) begin
                        r_d_mem_req <= 1'b1;
                        r_d_mem_we  <= r_class == C_STORE;
                        r_wait      <= '0;
                        r_state     <= S_MEM;
                    end
                end
                S_MEM: begin
                    if (d_mem_ready) begin
                        r_d_mem_req <= 1'b0;
                        r_d_mem_we  <= 1'b0;
                    end else if (r_wait == WAIT_MAX) begin
                        r_d_mem_req <= 1'b0;
                        r_d_mem_we  <= 1'b0;
                        r_halted    <= 1'b1;
                        r_bus_error <= 1'b1;
                        r_state     <= S_TRAP;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_WB: begin
                    r_rf_we     <= 1'b0;
                    r_pc_we     <= 1'b0;
                    r_pc_src    <= 1'b0;
                    r_i_mem_req <= 1'b1;
                    r_wait      <= '0;
                    r_state     <= S_FETCH;
                end
                default: r_state <= S_TRAP;
            endcase
            if (w_go_wb) begin
                r_pc_we  <= 1'b1;
                r_rf_we  <= !((r_class == C_STORE) || (r_class == C_BRANCH));
                r_pc_src <= (r_class == C_JAL) || (r_class == C_JALR) || ((r_class == C_BRANCH) && w_taken);
                r_count  <= r_count + 1'b1;
                r_state  <= S_WB;
            end
        end
    end

    assign i_mem_req   = r_i_mem_req;
    assign d_mem_req   = r_d_mem_req;
    assign d_mem_we    = r_d_mem_we;
    assign rf_we       = r_rf_we;
    assign alu_cmd     = r_alu_cmd;
    assign alu_src     = r_alu_src;
    assign pc_src      = r_pc_src;
    assign rf_src      = r_rf_src;
    assign pc_we       = r_pc_we;
    assign halted      = r_halted;
    assign illegal     = r_illegal;
    assign bus_error   = r_bus_error;
    assign instr_count = r_count;
endmodule

// File: tb/tb_uc_multiciclo.sv
// tb_uc_multiciclo: scoreboard bench for uc_multiciclo; writeback cycles are popped and
// compared by a monitor, latency/trap behaviour is checked by the stimulus process.
module tb_uc_multiciclo;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [3:0]  alu_flags = '0;
    logic        i_mem_ready = 1'b0;
    logic        d_mem_ready = 1'b0;
    logic        i_mem_req, d_mem_req, d_mem_we, rf_we, alu_src, pc_src, rf_src, pc_we;
    logic        halted, illegal, bus_error;
    logic [3:0]  alu_cmd;
    logic [31:0] instr_count;

    int          n_chk = 0;
    int          n_fail = 0;
    int          exp_count = 0;
    logic        prev_pc_we = 1'b0;
    logic [39:0] sb[$];

    uc_multiciclo #(.TIMEOUT_CYCLES(15), .COUNT_BITS(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .alu_flags(alu_flags),
        .i_mem_ready(i_mem_ready), .d_mem_ready(d_mem_ready), .i_mem_req(i_mem_req),
        .d_mem_req(d_mem_req), .d_mem_we(d_mem_we), .rf_we(rf_we), .alu_cmd(alu_cmd),
        .alu_src(alu_src), .pc_src(pc_src), .rf_src(rf_src), .pc_we(pc_we),
        .halted(halted), .illegal(illegal), .bus_error(bus_error), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] pk(input logic rw, input logic ps, input logic [3:0] cmd,
                                       input logic as, input logic rs, input logic [31:0] cnt);
        return {rw, ps, cmd, as, rs, cnt};
    endfunction

    task automatic push(input logic rw, input logic ps, input logic [3:0] cmd, input logic as, input logic rs);
        exp_count++;
        sb.push_back(pk(rw, ps, cmd, as, rs, exp_count));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("strobe_outside_wb", {62'd0, rf_we & ~pc_we, pc_we & prev_pc_we}, 64'd0);
            if (pc_we) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL wb_unexpected: got writeback with empty scoreboard");
                end else begin
                    chk("wb_fields", {24'd0, pk(rf_we, pc_src, alu_cmd, alu_src, rf_src, instr_count)},
                        {24'd0, sb.pop_front()});
                end
            end
        end
        prev_pc_we = pc_we;
    end

    task automatic do_reset();
        rst = 1'b1;
        i_mem_ready = 1'b0;
        d_mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {42'd0, i_mem_req, d_mem_req, d_mem_we, rf_we, alu_cmd, alu_src, pc_src,
            rf_src, pc_we, halted, illegal, bus_error, 32'd0} | {32'd0, instr_count}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_req", {31'd0, i_mem_req, instr_count}, {31'd0, 1'b1, 32'd0});
        exp_count = 0;
    endtask

    task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic [3:0] fl,
                       input int idly, input int ddly, output int cyc, output int nd, output int nw);
        int  ic = 0;
        int  dc = 0;
        bit  started = 0;
        bit  done = 0;
        opcode = op;
        funct3 = f3;
        alu_flags = fl;
        cyc = 0;
        nd = 0;
        nw = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (i_mem_req) started = 1;
            if (started) cyc++;
            if (d_mem_req) nd++;
            if (d_mem_we) nw++;
            done = pc_we || halted;
            i_mem_ready = i_mem_req && ic >= idly;
            if (i_mem_req) ic++;
            d_mem_ready = d_mem_req && dc >= ddly;
            if (d_mem_req) dc++;
        end
        i_mem_ready = 1'b0;
        d_mem_ready = 1'b0;
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL run_timeout: opcode %b never reached writeback or trap", op);
        end
    endtask

    initial begin
        int cyc, nd, nw, nreq;
        do_reset();
        // R-type
        push(1, 0, 4'd0, 0, 0);
        run(7'b0110011, 3'b000, 4'b0000, 0, 0, cyc, nd, nw);
        chk("r_cycles", cyc, 4);
        // STORE, data ready delayed 3 cycles
        push(0, 0, 4'd2, 1, 0);
        run(7'b0100011, 3'b011, 4'b0000, 0, 3, cyc, nd, nw);
        chk("store_cycles", cyc, 8);
        chk("store_dreq_cycles", nd, 4);
        chk("store_dwe_cycles", nw, 4);
        push(1, 0, 4'd1, 1, 1);
        run(7'b0000011, 3'b011, 4'b0000, 0, 0, cyc, nd, nw);
        chk("load_cycles", cyc, 5);
        chk("load_dwe_cycles", nw, 0);
        // branches
        push(0, 1, 4'd3, 0, 0);
        run(7'b1100011, 3'b000, 4'b0001, 0, 0, cyc, nd, nw);
        chk("beq_cycles", cyc, 4);
        push(0, 0, 4'd3, 0, 0);
        run(7'b1100011, 3'b000, 4'b0000, 0, 0, cyc, nd, nw);
        push(0, 0, 4'd3, 0, 0);
        run(7'b1100011, 3'b100, 4'b0110, 0, 0, cyc, nd, nw);
        push(0, 1, 4'd3, 0, 0);
        run(7'b1100011, 3'b100, 4'b0010, 0, 0, cyc, nd, nw);
        push(0, 1, 4'd3, 0, 0);
        run(7'b1100011, 3'b001, 4'b0000, 0, 0, cyc, nd, nw);
        push(0, 1, 4'd3, 0, 0);
        run(7'b1100011, 3'b101, 4'b0000, 0, 0, cyc, nd, nw);
        push(0, 0, 4'd3, 0, 0);
        run(7'b1100011, 3'b110, 4'b0000, 0, 0, cyc, nd, nw);
        push(0, 0, 4'd3, 0, 0);
        run(7'b1100011, 3'b111, 4'b1000, 0, 0, cyc, nd, nw);
        push(0, 1, 4'd3, 0, 0);
        run(7'b1100011, 3'b111, 4'b0000, 0, 0, cyc, nd, nw);
        // jumps and upper-immediate
        push(1, 1, 4'd5, 1, 0);
        run(7'b1101111, 3'b000, 4'b0000, 0, 0, cyc, nd, nw);
        push(1, 1, 4'd1, 1, 0);
        run(7'b1100111, 3'b000, 4'b0000, 0, 0, cyc, nd, nw);
        push(1, 0, 4'd4, 1, 0);
        run(7'b0110111, 3'b000, 4'b0000, 0, 0, cyc, nd, nw);
        push(1, 0, 4'd4, 1, 0);
        run(7'b0010111, 3'b000, 4'b0000, 0, 0, cyc, nd, nw);
        // fetch wait states, including ready on the last allowed wait cycle
        push(1, 0, 4'd1, 1, 0);
        run(7'b0010011, 3'b000, 4'b0000, 2, 0, cyc, nd, nw);
        chk("opimm_wait_cycles", cyc, 6);
        push(1, 0, 4'd0, 0, 0);
        run(7'b0110011, 3'b000, 4'b0000, 15, 0, cyc, nd, nw);
        chk("fetch_last_wait_ok", cyc, 19);
        chk("no_trap_at_limit", {halted, bus_error}, 2'b00);
        // illegal opcode
        run(7'b1111111, 3'b000, 4'b0000, 0, 0, cyc, nd, nw);
        chk("illegal_trap_cycles", cyc, 3);
        chk("illegal_flags", {halted, illegal, bus_error}, 3'b110);
        for (int k = 0; k < 5; k++) @(negedge clk);
        chk("trap_quiet", {i_mem_req, d_mem_req, d_mem_we, rf_we, pc_we}, 5'b0);
        chk("trap_count_frozen", instr_count, exp_count);
        do_reset();
        chk("reset_clears_illegal", {halted, illegal}, 2'b00);
        // fetch timeout: ready never arrives
        nreq = 1;
        for (int k = 0; k < 100 && !halted; k++) begin
            @(negedge clk);
            if (!halted && i_mem_req) nreq++;
        end
        chk("timeout_req_cycles", nreq, 16);
        chk("timeout_flags", {halted, illegal, bus_error}, 3'b101);
        do_reset();
        // branch with reserved funct3
        run(7'b1100011, 3'b010, 4'b0000, 0, 0, cyc, nd, nw);
        chk("branch_f3_illegal", {halted, illegal}, 2'b11);
        do_reset();
        push(1, 0, 4'd0, 0, 0);
        run(7'b0110011, 3'b000, 4'b0000, 0, 0, cyc, nd, nw);
        chk("after_reset_cycles", cyc, 4);
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
